// File: rtl/dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_if
//   Bundles the CPU-side request/response signals and the block-RAM port of the
//   data-memory controller.
//
//   CPU side : addr, write_data, memwrite, memread, sign_mask   (requests)
//              read_data, busy, misaligned_err                  (responses)
//   BRAM side: bram_addr, bram_din, bram_we                      (to RAM)
//              bram_dout                                         (from RAM)
//
//   modport slave  : the controller (dmem_ctrl)
//   modport master : the environment (CPU execute stage plus the block RAM)
// -----------------------------------------------------------------------------
interface dmem_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic [31:0]       addr;
  logic [31:0]       write_data;
  logic              memwrite;
  logic              memread;
  logic [3:0]        sign_mask;
  logic [31:0]       read_data;
  logic              busy;
  logic              misaligned_err;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_din;
  logic              bram_we;
  logic [31:0]       bram_dout;

  modport master (
    output addr, write_data, memwrite, memread, sign_mask, bram_dout,
    input  read_data, busy, misaligned_err, bram_addr, bram_din, bram_we
  );

  modport slave (
    input  addr, write_data, memwrite, memread, sign_mask, bram_dout,
    output read_data, busy, misaligned_err, bram_addr, bram_din, bram_we
  );
endinterface

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Data-memory controller between the CPU execute-stage memory port and a
//   word-wide, single-port, one-cycle-latency block RAM. Sub-word stores are
//   done as read-modify-write; loads are sign- or zero-extended. busy stalls
//   the CPU while an access is in flight.
//
//   Ports:
//     clk    - clock, all state changes on the rising edge
//     reset  - asynchronous, active-high reset
//     bus    - dmem_ctrl_if.slave (CPU request/response + BRAM port)
//     led    - 8-bit LED register (only with DMEM_LED_MMIO_EN defined)
//
//   Optional feature macro: DMEM_LED_MMIO_EN
//     When defined, byte address 32'h0000_2000 is an LED register: stores of
//     any size write write_data[7:0] to led, loads return {24'b0, led}.
//     When undefined, that address is simply out of range.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic       clk,
  input  logic       reset,
  dmem_ctrl_if.slave bus
`ifdef DMEM_LED_MMIO_EN
  ,
  output logic [7:0] led
`endif
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + (32'd4 << ADDR_W) - 32'd1;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W+1:0] addr_q;       // latched byte offset bits (word index + lane)
  logic [31:0]       data_q;       // store data, becomes the merged word in RMW_RD
  logic [3:0]        mask_q;
  logic              oor_q;        // access must not touch the BRAM
  logic [31:0]       read_data_q;
  logic              err_q;

  logic              req, is_byte, is_half, misaligned, in_range, led_hit, accept;
  logic              busy_c, we_c;
  logic [31:0]       din_c, load_value;
  logic [ADDR_W-1:0] cur_word;

  // Lane insertion for sub-word stores; other lanes keep the old word.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  size);
    logic [31:0] w;
    w = old_w;
    if (size == 3'b001)      w[{lane, 3'b000} +: 8]     = new_w[7:0];
    else if (size == 3'b011) w[{lane[1], 4'b0000} +: 16] = new_w[15:0];
    else                     w = new_w;
    return w;
  endfunction

  // Shift the selected lane down to bit 0 and extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] w,
                                              input logic [1:0]  lane,
                                              input logic [3:0]  mask);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (mask[2:0])
      3'b001:  return {{24{mask[3] & b[7]}}, b};
      3'b011:  return {{16{mask[3] & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign req        = bus.memread | bus.memwrite;
  assign is_byte    = (bus.sign_mask[2:0] == 3'b001);
  assign is_half    = (bus.sign_mask[2:0] == 3'b011);
  assign misaligned = (is_half & bus.addr[0]) |
                      (~is_byte & ~is_half & (bus.addr[1:0] != 2'b00));
  assign in_range   = (bus.addr >= BASE_ADDR) && (bus.addr <= LAST_ADDR);
  assign accept     = (state_q == IDLE) && req && !misaligned;

`ifdef DMEM_LED_MMIO_EN
  localparam logic [31:0] LED_ADDR = 32'h0000_2000;
  logic       led_sel_q;
  logic [7:0] led_q;

  assign led_hit = (bus.addr == LED_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_sel_q <= 1'b0;
      led_q     <= 8'h00;
    end else begin
      if (accept)                      led_sel_q <= led_hit;
      if (state_q == WR && led_sel_q)  led_q     <= data_q[7:0];
    end
  end

  assign led = led_q;
`else
  assign led_hit = 1'b0;
`endif

  // The BRAM must see the request address already in IDLE, because its data
  // comes back one cycle later, exactly when RD / RMW_RD samples it.
  assign cur_word      = (state_q == IDLE) ? bus.addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
  assign bus.bram_addr = cur_word - BASE_ADDR[ADDR_W+1:2];

  always_comb begin
    load_value = oor_q ? 32'h0 : extend_load(bus.bram_dout, addr_q[1:0], mask_q);
`ifdef DMEM_LED_MMIO_EN
    if (led_sel_q) load_value = {24'h0, led_q};
`endif
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    we_c    = 1'b0;
    din_c   = 32'h0;
    case (state_q)
      IDLE: begin
        if (req && !misaligned) begin
          busy_c = 1'b1;
          if (!bus.memwrite)                         state_d = RD;
          else if (led_hit || !(is_byte || is_half)) state_d = WR;
          else                                       state_d = RMW_RD;
        end
      end
      RD: begin
        busy_c  = 1'b1;
        state_d = DONE;
      end
      RMW_RD: begin
        busy_c  = 1'b1;
        state_d = RMW_WR;
      end
      RMW_WR, WR: begin
        busy_c  = 1'b1;
        we_c    = !oor_q;
        din_c   = data_q;
        state_d = DONE;
      end
      // DONE ignores the strobes: the CPU is still presenting the finished
      // request during this cycle.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= 32'h0;
      mask_q      <= 4'h0;
      oor_q       <= 1'b0;
      read_data_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= bus.addr[ADDR_W+1:0];
        data_q <= bus.write_data;
        mask_q <= bus.sign_mask;
        oor_q  <= !in_range || led_hit;
      end
      if (state_q == IDLE && req && misaligned) err_q       <= 1'b1;
      if (state_q == RD)                        read_data_q <= load_value;
      if (state_q == RMW_RD)
        data_q <= merge_lane(bus.bram_dout, data_q, addr_q[1:0], mask_q[2:0]);
    end
  end

  // bram_we / bram_din are decoded from the state only, so they fall as soon
  // as reset clears the state register.
  assign bus.busy           = busy_c;
  assign bus.bram_we        = we_c;
  assign bus.bram_din       = din_c;
  assign bus.read_data      = read_data_q;
  assign bus.misaligned_err = err_q;

endmodule
